// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings,
// controller state type, iteration count and a small sign helper.
package mips_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_t;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiply/divide datapath: a shift-add multiply step
// or a restoring divide step on a 64-bit {upper, lower} accumulator.
module mips_muldiv_step (
    input  logic        div_mode,
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] add_sum;
    logic [32:0] sh_rem;
    logic [32:0] diff;

    always_comb begin
        add_sum = '0;
        sh_rem  = '0;
        diff    = '0;
        acc_out = acc_in;
        if (div_mode) begin
            // Remainder is below the divisor, so the shifted value fits in 33 bits.
            sh_rem = acc_in[63:31];
            diff   = sh_rem - {1'b0, operand};
            if (sh_rem >= {1'b0, operand}) begin
                acc_out = {diff[31:0], acc_in[30:0], 1'b1};
            end else begin
                acc_out = {sh_rem[31:0], acc_in[30:0], 1'b0};
            end
        end else begin
            // Multiplier lives in the low half and is consumed LSB first.
            add_sum = {1'b0, acc_in[63:32]} + (acc_in[0] ? {1'b0, operand} : 33'd0);
            acc_out = {add_sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Handshake: start is sampled only in IDLE; busy covers RUN and FIX; done pulses once at commit.
import mips_pkg::*;

module mips_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state;
    md_state_t   state_next;
    logic [5:0]  iter_cnt;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] opnd;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;

    logic        md_start;
    logic        signed_op;
    logic        div_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign md_start  = start && (op[2] == 1'b0);
    assign signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign div_op    = (op == MD_DIV) || (op == MD_DIVU);
    assign a_in      = signed_op ? md_abs(operand_a) : operand_a;
    assign b_in      = signed_op ? md_abs(operand_b) : operand_b;

    assign prod_fix = neg_res ? (~acc + 64'd1) : acc;
    assign quot_fix = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];

    assign busy = (state != ST_IDLE);

    mips_muldiv_step u_step (
        .div_mode (is_div),
        .acc_in   (acc),
        .operand  (opnd),
        .acc_out  (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (md_start) state_next = ST_RUN;
            ST_RUN:  if (iter_cnt == 6'(MD_ITER - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            iter_cnt <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
                        acc      <= {32'd0, div_op ? a_in : b_in};
                        opnd     <= div_op ? b_in : a_in;
                        is_div   <= div_op;
                        neg_res  <= signed_op && (operand_a[31] ^ operand_b[31]);
                        neg_rem  <= signed_op && operand_a[31];
                        div_zero <= (operand_b == 32'd0);
                        iter_cnt <= '0;
                    end else if (start && op == MD_MTHI) begin
                        hi <= operand_a;
                    end else if (start && op == MD_MTLO) begin
                        lo <= operand_a;
                    end
                end
                ST_RUN: begin
                    acc      <= acc_next;
                    iter_cnt <= iter_cnt + 6'd1;
                end
                ST_FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // Zero divisor leaves the remainder equal to the dividend already.
                        lo <= div_zero ? 32'hFFFF_FFFF : quot_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed vector table, corner sequences and random
// operations checked against an arithmetic reference model.
module tb_mips_muldiv;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    mips_muldiv dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Truncating signed/unsigned arithmetic on 64-bit values.
    task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rh, output logic [31:0] rl);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = '0;
        rl = '0;
        case (o)
            MD_MULT: begin
                sq = sa * sb;
                up = sq;
                rh = up[63:32];
                rl = up[31:0];
            end
            MD_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                rh = up[63:32];
                rl = up[31:0];
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    up = sq;
                    rl = up[31:0];
                    up = sr;
                    rh = up[31:0];
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    rl = 32'hFFFF_FFFF;
                    rh = a;
                end else begin
                    rl = a / b;
                    rh = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op        = 3'($urandom_range(0, 3));
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit inject);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        logic [31:0] qh;
        logic [31:0] ql;
        int          lat;
        int          busy_cyc;
        exp_q.push_back(eh);
        exp_q.push_back(el);
        prev_hi = hi;
        prev_lo = lo;
        issue(o, a, b);
        busy_cyc = int'(busy);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (inject && k == 5) begin
                start     = 1'b1;
                op        = MD_MULT;
                operand_a = 32'd3;
                operand_b = 32'd5;
            end
            if (inject && k == 7) start = 1'b0;
            @(posedge clk);
            #1;
            if (k == 10) begin
                check({name, "_hold_hi"}, hi, prev_hi);
                check({name, "_hold_lo"}, lo, prev_lo);
            end
            if (done) begin
                lat = k;
                break;
            end
            busy_cyc += int'(busy);
        end
        start = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'd33);
        check({name, "_busy_cycles"}, 32'(busy_cyc), 32'd33);
        qh = exp_q.pop_front();
        ql = exp_q.pop_front();
        check({name, "_hi"}, hi, qh);
        check({name, "_lo"}, lo, ql);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] rh;
        logic [31:0] rl;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  ro;
        logic [31:0] save_hi;
        logic [31:0] save_lo;
        int          done_seen;

        vecs[0] = '{MD_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{MD_DIVU,  32'd100,        32'd7,         32'd2,         32'd14};
        vecs[4] = '{MD_DIVU,  32'h0000_1234,  32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
        vecs[5] = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};

        reset = 1'b1;
        start = 1'b0;
        op = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_md($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, 1'b0);
        end

        // MTHI / MTLO: one-edge latency, no busy or done
        save_lo = lo;
        issue(MD_MTHI, 32'hA5A5_A5A5, 32'd0);
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo", lo, save_lo);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_done", 32'(done), 32'd0);
        issue(MD_MTLO, 32'h5A5A_0001, 32'd0);
        check("mtlo_lo", lo, 32'h5A5A_0001);
        check("mtlo_hi", hi, 32'hA5A5_A5A5);
        check("mtlo_busy", 32'(busy), 32'd0);

        // Reserved op codes leave everything untouched
        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        check("op6_hi", hi, 32'hA5A5_A5A5);
        check("op6_lo", lo, 32'h5A5A_0001);
        check("op6_busy", 32'(busy), 32'd0);
        issue(3'd7, 32'h3333_3333, 32'h4444_4444);
        check("op7_lo", lo, 32'h5A5A_0001);

        // A second start during RUN must be ignored
        run_md("mid_start", MD_DIVU, 32'd1000, 32'd9, 32'd1, 32'd111, 1'b1);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (i % 5 == 1) rb = 32'($urandom_range(1, 40));
            if (i % 7 == 2) ra = 32'h8000_0000;
            ref_model(ro, ra, rb, rh, rl);
            run_md($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, rh, rl, 1'b0);
        end

        // Reset at cycle 10 of a MULT aborts without a done pulse
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        issue(MD_MULT, 32'h1234, 32'h5678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_hi_after", hi, 32'd0);

        // Unit still functional after the abort
        run_md("post_abort", MD_MULTU, 32'd12345, 32'd6789, 32'd0, 32'd83810205, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
